// File: rtl/uart_rx_pkg.sv
// Shared constants, state encoding and vote helper for the UART receive front end.
package uart_rx_pkg;

  localparam int unsigned DATA_W_DEF   = 8;
  localparam int unsigned MIN_PRESCALE = 4;
  localparam int unsigned BIT_IDX_W    = 4;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } rx_state_e;

  function automatic logic majority3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

endpackage

// File: rtl/uart_rx_edge_bit_counter.sv
// Oversample edge counter (0..period-1) and frame bit index; the index advances
// each time the edge counter wraps.
module uart_rx_edge_bit_counter
  import uart_rx_pkg::*;
#(
  parameter int unsigned PRESCALE_W = 6,
  parameter int unsigned IDX_W      = BIT_IDX_W
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  clear_i,
  input  logic                  start_i,
  input  logic                  en_i,
  input  logic [PRESCALE_W-1:0] period_i,
  output logic [PRESCALE_W-1:0] edge_cnt_o,
  output logic [IDX_W-1:0]      bit_index_o,
  output logic                  wrap_c_o
);

  logic [PRESCALE_W-1:0] edge_q, edge_d;
  logic [IDX_W-1:0]      bit_q, bit_d;

  assign wrap_c_o    = en_i && (edge_q == (period_i - PRESCALE_W'(1)));
  assign edge_cnt_o  = edge_q;
  assign bit_index_o = bit_q;

  // The start cycle itself is edge 0, so a start loads edge 1 for the next cycle.
  always_comb begin
    edge_d = edge_q;
    bit_d  = bit_q;
    if (clear_i) begin
      edge_d = '0;
      bit_d  = '0;
    end else if (start_i) begin
      edge_d = PRESCALE_W'(1);
      bit_d  = '0;
    end else if (en_i) begin
      if (wrap_c_o) begin
        edge_d = '0;
        bit_d  = bit_q + IDX_W'(1);
      end else begin
        edge_d = edge_q + PRESCALE_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      edge_q <= '0;
      bit_q  <= '0;
    end else begin
      edge_q <= edge_d;
      bit_q  <= bit_d;
    end
  end

endmodule

// File: rtl/uart_rx_data_sampler.sv
// UART receive front end: start detection, 3-sample majority vote per bit and frame tracking.
// Optional RX_SYNC_EN: route rx_in through a 2-flop synchronizer before any use.
module uart_rx_data_sampler
  import uart_rx_pkg::*;
#(
  parameter int unsigned DATA_W     = DATA_W_DEF,
  parameter int unsigned PRESCALE_W = 6
) (
  input  logic                  clk_based_on_prescale,
  input  logic                  asy_reset,
  input  logic                  rx_in,
  input  logic [PRESCALE_W-1:0] prescale,
  input  logic                  parity_enable,
  output logic                  sampled_data,
  output logic                  sampled_data_valid,
  output logic                  parity_check_enable,
  output logic [BIT_IDX_W-1:0]  bit_index,
  output logic                  frame_done,
  output logic                  start_glitch,
  output logic                  stop_error,
  output logic                  busy
);

  logic rx_s;

`ifdef RX_SYNC_EN
  logic [1:0] sync_q;

  always_ff @(posedge clk_based_on_prescale or negedge asy_reset) begin
    if (!asy_reset) sync_q <= 2'b11;
    else            sync_q <= {sync_q[0], rx_in};
  end

  assign rx_s = sync_q[1];
`else
  assign rx_s = rx_in;
`endif

  rx_state_e             state_q, state_d;
  logic [PRESCALE_W-1:0] p_q, p_d;
  logic                  par_en_q, par_en_d;
  logic                  prev_q;
  logic                  s0_q, s0_d, s1_q, s1_d;
  logic                  sampled_q, sampled_d;
  logic                  valid_q, valid_d;
  logic                  par_strobe_q, par_strobe_d;
  logic                  pce_q, pce_d;
  logic                  done_q, done_d;
  logic                  glitch_q, glitch_d;
  logic                  stop_err_q, stop_err_d;
  logic                  busy_q, busy_d;

  logic                  cnt_clear, cnt_start, cnt_en, wrap_c;
  logic [PRESCALE_W-1:0] edge_cnt;
  logic [BIT_IDX_W-1:0]  bit_idx;

  uart_rx_edge_bit_counter #(
    .PRESCALE_W (PRESCALE_W),
    .IDX_W      (BIT_IDX_W)
  ) u_cnt (
    .clk         (clk_based_on_prescale),
    .rst_n       (asy_reset),
    .clear_i     (cnt_clear),
    .start_i     (cnt_start),
    .en_i        (cnt_en),
    .period_i    (p_q),
    .edge_cnt_o  (edge_cnt),
    .bit_index_o (bit_idx),
    .wrap_c_o    (wrap_c)
  );

  // Effective ratio: clamp to the minimum, then force even.
  logic [PRESCALE_W-1:0] prescale_clamped, prescale_eff, half;
  logic                  fall, at_s0, at_s1, at_vote, vote;

  assign prescale_clamped = (prescale < PRESCALE_W'(MIN_PRESCALE)) ?
                            PRESCALE_W'(MIN_PRESCALE) : prescale;
  assign prescale_eff     = {prescale_clamped[PRESCALE_W-1:1], 1'b0};
  assign half             = {1'b0, p_q[PRESCALE_W-1:1]};

  assign fall    = prev_q & ~rx_s;
  assign at_s0   = (edge_cnt == (half - PRESCALE_W'(1)));
  assign at_s1   = (edge_cnt == half);
  assign at_vote = (edge_cnt == (half + PRESCALE_W'(1)));
  assign vote    = majority3(s0_q, s1_q, rx_s);

  always_comb begin
    state_d      = state_q;
    p_d          = p_q;
    par_en_d     = par_en_q;
    s0_d         = s0_q;
    s1_d         = s1_q;
    sampled_d    = sampled_q;
    valid_d      = 1'b0;
    par_strobe_d = 1'b0;
    pce_d        = pce_q;
    done_d       = 1'b0;
    glitch_d     = 1'b0;
    stop_err_d   = 1'b0;
    cnt_clear    = 1'b0;
    cnt_start    = 1'b0;
    cnt_en       = 1'b0;

    if (state_q != IDLE) begin
      cnt_en = 1'b1;
      if (at_s0) s0_d = rx_s;
      if (at_s1) s1_d = rx_s;
    end

    // The enable window closes the cycle after the parity strobe.
    if (par_strobe_q) pce_d = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (fall) begin
          state_d   = START;
          p_d       = prescale_eff;
          par_en_d  = parity_enable;
          cnt_start = 1'b1;
        end
      end
      START: begin
        if (at_vote && vote) begin
          glitch_d  = 1'b1;
          state_d   = IDLE;
          cnt_clear = 1'b1;
        end else if (wrap_c) begin
          state_d = DATA;
          pce_d   = par_en_q;
        end
      end
      DATA: begin
        if (at_vote) begin
          sampled_d = vote;
          valid_d   = 1'b1;
        end
        if (wrap_c && (bit_idx == BIT_IDX_W'(DATA_W))) begin
          state_d = par_en_q ? PARITY : STOP;
        end
      end
      PARITY: begin
        if (at_vote) begin
          sampled_d    = vote;
          valid_d      = 1'b1;
          par_strobe_d = 1'b1;
        end
        if (wrap_c) state_d = STOP;
      end
      STOP: begin
        // Leave mid stop bit so a following start edge is seen.
        if (at_vote) begin
          done_d     = 1'b1;
          stop_err_d = ~vote;
          state_d    = IDLE;
          cnt_clear  = 1'b1;
        end
      end
      default: begin
        state_d   = IDLE;
        cnt_clear = 1'b1;
      end
    endcase

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk_based_on_prescale or negedge asy_reset) begin
    if (!asy_reset) begin
      state_q      <= IDLE;
      p_q          <= '0;
      par_en_q     <= 1'b0;
      prev_q       <= 1'b0;
      s0_q         <= 1'b0;
      s1_q         <= 1'b0;
      sampled_q    <= 1'b0;
      valid_q      <= 1'b0;
      par_strobe_q <= 1'b0;
      pce_q        <= 1'b0;
      done_q       <= 1'b0;
      glitch_q     <= 1'b0;
      stop_err_q   <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      p_q          <= p_d;
      par_en_q     <= par_en_d;
      prev_q       <= rx_s;
      s0_q         <= s0_d;
      s1_q         <= s1_d;
      sampled_q    <= sampled_d;
      valid_q      <= valid_d;
      par_strobe_q <= par_strobe_d;
      pce_q        <= pce_d;
      done_q       <= done_d;
      glitch_q     <= glitch_d;
      stop_err_q   <= stop_err_d;
      busy_q       <= busy_d;
    end
  end

  assign sampled_data        = sampled_q;
  assign sampled_data_valid  = valid_q;
  assign parity_check_enable = pce_q;
  assign bit_index           = bit_idx;
  assign frame_done          = done_q;
  assign start_glitch        = glitch_q;
  assign stop_error          = stop_err_q;
  assign busy                = busy_q;

endmodule

// File: tb/tb_uart_rx_data_sampler.sv
// Scoreboard bench for uart_rx_data_sampler: frames are driven bit by bit, expected
// strobes/pulses are queued with their cycle and compared when the DUT emits them.
module tb_uart_rx_data_sampler;

`ifdef RX_SYNC_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 0;
`endif

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       rx_in = 1'b1;
  logic [5:0] prescale = 6'd8;
  logic       parity_enable = 1'b0;

  logic       sampled_data, sampled_data_valid, parity_check_enable;
  logic [3:0] bit_index;
  logic       frame_done, start_glitch, stop_error, busy;

  int cyc = 0;
  int n_checks = 0;
  int n_errors = 0;

  typedef struct {
    int cyc;
    bit data;
    bit pce;
    int idx;
    bit is_par;
  } strobe_t;

  typedef struct {
    int cyc;
    bit err;
  } done_t;

  strobe_t sq[$];
  done_t   dq[$];
  int      gq[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  uart_rx_data_sampler #(
    .DATA_W     (8),
    .PRESCALE_W (6)
  ) dut (
    .clk_based_on_prescale (clk),
    .asy_reset             (rst_n),
    .rx_in                 (rx_in),
    .prescale              (prescale),
    .parity_enable         (parity_enable),
    .sampled_data          (sampled_data),
    .sampled_data_valid    (sampled_data_valid),
    .parity_check_enable   (parity_check_enable),
    .bit_index             (bit_index),
    .frame_done            (frame_done),
    .start_glitch          (start_glitch),
    .stop_error            (stop_error),
    .busy                  (busy)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic logic [31:0] all_outs();
    return 32'({sampled_data, sampled_data_valid, parity_check_enable, bit_index,
                frame_done, start_glitch, stop_error, busy});
  endfunction

  task automatic drive_cycles(input logic v, input int n);
    repeat (n) begin
      @(posedge clk); #1;
      rx_in = v;
    end
  endtask

  task automatic monitor();
    bit last_par = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        last_par = 1'b0;
      end else begin
        if (last_par) check_eq("pce_fall", 32'(parity_check_enable), 32'(0));
        last_par = 1'b0;
        if (sampled_data_valid) begin
          if (sq.size() == 0) begin
            check_eq("unexp_strobe", 32'(sampled_data_valid), 32'(0));
          end else begin
            strobe_t e;
            e = sq.pop_front();
            check_eq("strobe_cyc", 32'(cyc), 32'(e.cyc));
            check_eq("strobe_data", 32'(sampled_data), 32'(e.data));
            check_eq("strobe_pce", 32'(parity_check_enable), 32'(e.pce));
            check_eq("strobe_idx", 32'(bit_index), 32'(e.idx));
            last_par = e.is_par;
          end
        end
        if (frame_done) begin
          if (dq.size() == 0) begin
            check_eq("unexp_done", 32'(frame_done), 32'(0));
          end else begin
            done_t d;
            d = dq.pop_front();
            check_eq("done_cyc", 32'(cyc), 32'(d.cyc));
            check_eq("stop_err", 32'(stop_error), 32'(d.err));
            check_eq("done_busy", 32'(busy), 32'(0));
          end
        end else if (stop_error) begin
          check_eq("stray_stop_err", 32'(stop_error), 32'(0));
        end
        if (start_glitch) begin
          if (gq.size() == 0) begin
            check_eq("unexp_glitch", 32'(start_glitch), 32'(0));
          end else begin
            int g;
            g = gq.pop_front();
            check_eq("glitch_cyc", 32'(cyc), 32'(g));
            check_eq("glitch_busy", 32'(busy), 32'(0));
          end
        end
      end
    end
  endtask

  // pre is the value on the prescale port, p the ratio the DUT should use.
  task automatic send_frame(input logic [7:0] data, input logic [5:0] pre, input int p,
                            input bit par_en, input bit stop_val,
                            input int flip_bit, input int flip_edge,
                            input int chg_bit, input int abort_bit);
    bit bits[$];
    int c0;
    int stop_idx;
    prescale      = pre;
    parity_enable = par_en;
    bits.push_back(1'b0);
    for (int i = 0; i < 8; i++) bits.push_back(data[i]);
    if (par_en) bits.push_back(^data);
    bits.push_back(stop_val);
    stop_idx = bits.size() - 1;

    @(posedge clk); #1;
    c0 = cyc;
    for (int b = 1; b < stop_idx; b++) begin
      if (abort_bit < 0 || b < abort_bit)
        sq.push_back('{cyc: c0 + LAT + b*p + p/2 + 2, data: bits[b], pce: par_en,
                       idx: b, is_par: (par_en && b == stop_idx - 1)});
    end
    if (abort_bit < 0)
      dq.push_back('{cyc: c0 + LAT + stop_idx*p + p/2 + 2, err: !stop_val});

    for (int b = 0; b <= stop_idx; b++) begin
      for (int e = 0; e < p; e++) begin
        if (b != 0 || e != 0) begin
          @(posedge clk); #1;
        end
        if (b == abort_bit && e == 2) begin
          rst_n = 1'b0;
          rx_in = 1'b1;
          #1;
          check_eq("abort_outs", all_outs(), 32'(0));
          repeat (3) @(posedge clk);
          #1;
          rst_n = 1'b1;
          return;
        end
        if (b == chg_bit && e == 0) prescale = 6'd8;
        if (b == stop_idx && e == 0) prescale = pre;
        rx_in = (b == flip_bit && e == flip_edge) ? ~bits[b] : bits[b];
      end
    end
  endtask

  task automatic send_glitch(input logic [5:0] pre, input int p);
    int c0;
    prescale      = pre;
    parity_enable = 1'b0;
    @(posedge clk); #1;
    c0 = cyc;
    gq.push_back(c0 + LAT + p/2 + 2);
    rx_in = 1'b0;
    drive_cycles(1'b0, 1);
    drive_cycles(1'b1, 2*p);
    check_eq("glitch_idle_busy", 32'(busy), 32'(0));
  endtask

  initial begin
    fork
      monitor();
    join_none

    repeat (4) @(posedge clk);
    #1;
    check_eq("reset_state", all_outs(), 32'(0));
    rst_n = 1'b1;
    drive_cycles(1'b1, 5);
    check_eq("idle_busy", 32'(busy), 32'(0));

    // 0xA5 with even parity, P=8
    send_frame(8'hA5, 6'd8, 8, 1'b1, 1'b1, -1, -1, -1, -1);
    drive_cycles(1'b1, 10);

    // Start glitch, then a clean frame
    send_glitch(6'd8, 8);
    send_frame(8'h5A, 6'd8, 8, 1'b0, 1'b1, -1, -1, -1, -1);
    drive_cycles(1'b1, 10);

    // Stop-bit error with line held low afterwards: no restart
    send_frame(8'h3C, 6'd16, 16, 1'b0, 1'b0, -1, -1, -1, -1);
    drive_cycles(1'b0, 48);
    check_eq("low_line_busy", 32'(busy), 32'(0));
    check_eq("low_line_idx", 32'(bit_index), 32'(0));
    drive_cycles(1'b1, 10);
    send_frame(8'hC3, 6'd16, 16, 1'b0, 1'b1, -1, -1, -1, -1);
    drive_cycles(1'b1, 10);

    // Single corrupted sample in data bit 3 (frame bit 4)
    send_frame(8'h55, 6'd16, 16, 1'b0, 1'b1, 4, 8, -1, -1);
    drive_cycles(1'b1, 10);

    // Reset mid-frame, then a full frame
    send_frame(8'h96, 6'd8, 8, 1'b1, 1'b1, -1, -1, -1, 4);
    drive_cycles(1'b1, 10);
    check_eq("post_abort_busy", 32'(busy), 32'(0));
    send_frame(8'h96, 6'd8, 8, 1'b1, 1'b1, -1, -1, -1, -1);
    drive_cycles(1'b1, 10);

    // Back-to-back at P=32 with a mid-frame prescale change
    send_frame(8'h00, 6'd32, 32, 1'b0, 1'b1, -1, -1, 2, -1);
    send_frame(8'hFF, 6'd32, 32, 1'b0, 1'b1, -1, -1, -1, -1);
    drive_cycles(1'b1, 10);

    // Odd prescale rounds down to 8
    send_frame(8'h81, 6'd9, 8, 1'b1, 1'b1, -1, -1, -1, -1);
    drive_cycles(1'b1, 40);

    check_eq("strobes_left", 32'(sq.size()), 32'(0));
    check_eq("dones_left", 32'(dq.size()), 32'(0));
    check_eq("glitches_left", 32'(gq.size()), 32'(0));

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/uart_rx_data_sampler.md
Name: uart_rx_data_sampler

Overview:
Front stage of the UART receiver. It detects the start bit on the serial line and oversamples each bit with a 3-sample majority vote. It tracks frame position and emits one sampled bit per bit period with a valid strobe. It drives the parity checker directly through sampled_data, sampled_data_valid and parity_check_enable, and flags start glitches and stop-bit errors.

Parameters:
DATA_W, 8, data bits per frame (LSB first)
PRESCALE_W, 6, width of prescale input (oversampling ratio up to 32)

Ports:
clk_based_on_prescale  in  1  oversampling clock (prescale x baud)
asy_reset  in  1  asynchronous reset, active-low
rx_in  in  1  serial line, idle high
prescale  in  PRESCALE_W  oversampling ratio; legal even values 4..32
parity_enable  in  1  1 = frame carries a parity bit after data
sampled_data  out  1  majority-voted bit value
sampled_data_valid  out  1  one-cycle strobe, sampled_data valid for data and parity bits
parity_check_enable  out  1  high from first data bit through parity bit (parity frames only)
bit_index  out  4  index of the current bit within the frame (0 = start)
frame_done  out  1  one-cycle pulse at stop-bit decision
start_glitch  out  1  one-cycle pulse when the start bit votes 1
stop_error  out  1  one-cycle pulse with frame_done when the stop bit votes 0
busy  out  1  high in any state except IDLE

Behaviour:
- Reset (async, active-low): state IDLE. All outputs 0. Edge counter, bit counter, sample registers and latched config are cleared. A reset mid-frame aborts the frame with no pulses.
- Config: prescale and parity_enable are latched on the cycle the start is detected; mid-frame changes are ignored. Latched prescale <4 is treated as 4, and the LSB is ignored (odd values round down). P denotes the latched value.
- Start detection (IDLE): a falling edge on rx_in (previous sample 1, current 0) marks edge_cnt = 0 of the start bit. The next state is START.
- Edge counter runs 0..P-1 within each bit, wraps to 0 and increments bit_index on wrap.
- Sampling: rx_in is captured at edge_cnt = P/2-1, P/2 and P/2+1. The majority is computed at P/2+1, and sampled_data plus sampled_data_valid appear on the following cycle (registered). sampled_data holds its value until the next vote.
- States:
  IDLE -> START on falling edge.
  START: if the vote is 1, pulse start_glitch and go to IDLE with no valid strobe. Otherwise go to DATA at the bit wrap.
  DATA: DATA_W bits, each producing a valid strobe. After the last bit, go to PARITY if parity_enable, else STOP.
  PARITY: one bit with a valid strobe, then STOP.
  STOP: the vote is registered. frame_done pulses on the cycle sampled_data would update. stop_error pulses simultaneously if the vote is 0. The block then goes to IDLE immediately (mid stop bit), so back-to-back frames are accepted.
- Outputs by state:
  The valid strobe is never asserted for start or stop bits.
  parity_check_enable rises at the start of DATA bit 0 (edge_cnt 0) and falls on the cycle after the parity valid strobe. It is always 0 when parity_enable is 0. This gives the parity checker exactly DATA_W+1 strobes inside one enable window.
  bit_index is 0 in START, 1..DATA_W in DATA, DATA_W+1 in PARITY and the last value in STOP. It is 0 in IDLE.
- After stop_error the line may still be low. IDLE requires a genuine 1->0 transition, so no false restart occurs.
- The previous-sample register updates every cycle regardless of state.

Optional Feature:
RX_SYNC_EN: when defined, rx_in passes through a 2-flop synchronizer (reset to 1) before any use. All sampling and edge detection are delayed 2 cycles, and output latency from line to strobe grows by 2 cycles. When undefined, rx_in is used directly and must already be synchronous.

Decomposition:
- Shared package uart_rx_pkg:
  - state enum (IDLE, START, DATA, PARITY, STOP)
  - MIN_PRESCALE = 4
  - default DATA_W
  - bit_index width constant
- One natural sub-module, uart_rx_edge_bit_counter: edge_cnt and bit_index counters with an enable and wrap. It is instantiated by the FSM, which owns sampling and outputs.

Test Plan:
- prescale=8, parity_enable=1, send 0xA5 LSB first + even parity 0 + stop 1:
  - 9 valid strobes with sampled_data = 1,0,1,0,0,1,0,1,0
  - each strobe at edge_cnt P/2+2 of its bit
  - parity_check_enable high across all 9, then frame_done with no stop_error
- prescale=8, rx_in low for 2 cycles then high -> start_glitch pulse, no valid strobe, busy back to 0, next clean frame received correctly.
- prescale=16, parity off, 0x3C with stop bit 0:
  - 8 strobes, parity_check_enable stays 0
  - frame_done and stop_error pulse together
  - no restart until rx_in returns 1 and falls again
- prescale=16, invert the single sample at edge_cnt 8 of data bit 3 -> majority keeps correct value, byte 0x55 recovered.
- Assert asy_reset during DATA bit 4 -> all outputs 0 immediately, no frame_done. A frame sent after release is received correctly.
- prescale=32, back-to-back frames 0x00 then 0xFF with a 1-bit stop -> two frame_done pulses and 16 correct strobes. A prescale change to 8 mid-frame is ignored until the next start.
